// File: rtl/bcrypt_sched_pkg.sv
// Shared definitions for the bcrypt ingress scheduler: framing codes,
// scheduler state encoding and packet-type constants.
package bcrypt_sched_pkg;

   localparam logic [1:0] CTRL_DATA        = 2'd0;
   localparam logic [1:0] CTRL_INIT_START  = 2'd1;
   localparam logic [1:0] CTRL_CRYPT_START = 2'd2;
   localparam logic [1:0] CTRL_END         = 2'd3;

   localparam logic PKT_INIT  = 1'b0;
   localparam logic PKT_CRYPT = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      STREAM = 2'd2
   } sched_state_t;

   // True for the two codes that open a packet
   function automatic logic is_start(input logic [1:0] code);
      return (code == CTRL_INIT_START) || (code == CTRL_CRYPT_START);
   endfunction

endpackage

// File: rtl/bcrypt_rr_pick.sv
// Rotate-priority encoder: returns the first eligible proxy at or after
// rr_ptr, wrapping modulo NUM_PROXIES. Purely combinational.
module bcrypt_rr_pick
   import bcrypt_sched_pkg::*;
#(
   parameter int NUM_PROXIES = 2,
   parameter int PTR_W       = 4
) (
   input  logic [NUM_PROXIES-1:0] elig,
   input  logic [PTR_W-1:0]       rr_ptr,
   output logic [PTR_W-1:0]       sel,
   output logic                   any
);

   logic [2*NUM_PROXIES-1:0] elig_dbl;
   logic [NUM_PROXIES-1:0]   elig_rot;
   logic [PTR_W-1:0]         off;
   logic [PTR_W:0]           sum;

   // Doubling the vector lets a plain right shift act as a rotate
   assign elig_dbl = {elig, elig};
   assign elig_rot = NUM_PROXIES'(elig_dbl >> rr_ptr);

   // Lowest set bit of the rotated vector, then map back to a proxy index
   always_comb begin
      off = '0;
      for (int i = NUM_PROXIES - 1; i >= 0; i--) begin
         if (elig_rot[i]) off = PTR_W'(i);
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (PTR_W + 1)'(NUM_PROXIES)) sum = sum - (PTR_W + 1)'(NUM_PROXIES);
      sel = sum[PTR_W-1:0];
      any = |elig;
   end

endmodule

// File: rtl/bcrypt_dispatch_sched.sv
// Ingress scheduler for the bcrypt proxies: picks a proxy per packet
// round-robin among ready ones, streams the packet on the shared bus and
// masks the served proxy for HOLDOFF cycles so lagging ready flags are not
// trusted. Optional statistics counters: define BCRYPT_SCHED_STATS_EN.
module bcrypt_dispatch_sched
   import bcrypt_sched_pkg::*;
#(
   parameter int NUM_PROXIES = 2,
   parameter int HOLDOFF     = 6,
   parameter int PTR_W       = 4
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic [7:0]             s_din,
   input  logic [1:0]             s_ctrl,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [7:0]             din,
   output logic [1:0]             ctrl,
   output logic [NUM_PROXIES-1:0] wr_en,
   input  logic [NUM_PROXIES-1:0] init_ready,
   input  logic [NUM_PROXIES-1:0] crypt_ready,
   output logic                   busy,
`ifdef BCRYPT_SCHED_STATS_EN
   output logic [15:0]            pkt_init_cnt,
   output logic [15:0]            pkt_crypt_cnt,
   output logic [7:0]             err_cnt,
`endif
   output logic                   err_proto
);

   sched_state_t           state_reg;
   logic                   run_reg;
   logic                   type_reg;
   logic                   first_reg;
   logic [PTR_W-1:0]       sel_reg;
   logic [PTR_W-1:0]       rr_ptr_reg;
   logic [7:0]             din_reg;
   logic [1:0]             ctrl_reg;
   logic [NUM_PROXIES-1:0] wr_en_reg;
   logic                   err_reg;

   logic [NUM_PROXIES-1:0] holdoff_active;
   logic [NUM_PROXIES-1:0] elig;
   logic [NUM_PROXIES-1:0] sel_onehot;
   logic [PTR_W-1:0]       pick_sel;
   logic                   pick_any;
   logic [PTR_W-1:0]       rr_next;
   logic                   end_fire;
   logic                   err_fire;

   // s_ready must follow s_ctrl in IDLE, so it is decoded from registered
   // state; run_reg keeps it low through reset and the first cycle after.
   assign s_ready = run_reg &
                    (((state_reg == IDLE) & ~is_start(s_ctrl)) | (state_reg == STREAM));

   assign busy       = (state_reg != IDLE);
   assign din        = din_reg;
   assign ctrl       = ctrl_reg;
   assign wr_en      = wr_en_reg;
   assign err_proto  = err_reg;

   assign elig       = ((type_reg == PKT_INIT) ? init_ready : crypt_ready) & ~holdoff_active;
   assign sel_onehot = NUM_PROXIES'(1) << sel_reg;
   assign rr_next    = (sel_reg == PTR_W'(NUM_PROXIES - 1)) ? '0 : sel_reg + PTR_W'(1);

   // END is never a start code, so an accepted END in STREAM is always forwarded
   assign end_fire = (state_reg == STREAM) & s_valid & (s_ctrl == CTRL_END);

   // Stray non-start byte in IDLE, or a second start code inside a packet
   assign err_fire = run_reg & s_valid &
                     (((state_reg == IDLE) & ~is_start(s_ctrl)) |
                      ((state_reg == STREAM) & is_start(s_ctrl) & ~first_reg));

   bcrypt_rr_pick #(
      .NUM_PROXIES (NUM_PROXIES),
      .PTR_W       (PTR_W)
   ) u_pick (
      .elig   (elig),
      .rr_ptr (rr_ptr_reg),
      .sel    (pick_sel),
      .any    (pick_any)
   );

   // Per-proxy hold-off counters; a fresh END load wins over the decrement
   for (genvar gi = 0; gi < NUM_PROXIES; gi++) begin : g_holdoff
      logic [3:0] cnt_reg;

      // Load on END of a packet sent here, otherwise count down to zero
      always_ff @(posedge CLK or negedge rst_n) begin
         if (!rst_n)
            cnt_reg <= '0;
         else if (end_fire && (sel_reg == PTR_W'(gi)))
            cnt_reg <= 4'(HOLDOFF);
         else if (cnt_reg != '0)
            cnt_reg <= cnt_reg - 4'd1;
      end

      assign holdoff_active[gi] = (cnt_reg != '0);
   end

   // Scheduler FSM with registered bus outputs
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         run_reg    <= 1'b0;
         type_reg   <= PKT_INIT;
         first_reg  <= 1'b0;
         sel_reg    <= '0;
         rr_ptr_reg <= '0;
         din_reg    <= '0;
         ctrl_reg   <= CTRL_DATA;
         wr_en_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         run_reg   <= 1'b1;
         wr_en_reg <= '0;
         err_reg   <= err_fire;
         case (state_reg)
            IDLE: begin
               // Start byte is left on the source until STREAM takes it
               if (run_reg && s_valid && is_start(s_ctrl)) begin
                  type_reg  <= (s_ctrl == CTRL_INIT_START) ? PKT_INIT : PKT_CRYPT;
                  state_reg <= SELECT;
               end
            end
            SELECT: begin
               if (pick_any) begin
                  sel_reg   <= pick_sel;
                  first_reg <= 1'b1;
                  state_reg <= STREAM;
               end
            end
            STREAM: begin
               if (s_valid && !(is_start(s_ctrl) && !first_reg)) begin
                  din_reg   <= s_din;
                  ctrl_reg  <= s_ctrl;
                  wr_en_reg <= sel_onehot;
                  first_reg <= 1'b0;
                  if (s_ctrl == CTRL_END) begin
                     rr_ptr_reg <= rr_next;
                     state_reg  <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef BCRYPT_SCHED_STATS_EN
   logic [15:0] pkt_init_cnt_reg;
   logic [15:0] pkt_crypt_cnt_reg;
   logic [7:0]  err_cnt_reg;

   // Packet counters wrap, error counter saturates
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         pkt_init_cnt_reg  <= '0;
         pkt_crypt_cnt_reg <= '0;
         err_cnt_reg       <= '0;
      end else begin
         if (end_fire && (type_reg == PKT_INIT))
            pkt_init_cnt_reg <= pkt_init_cnt_reg + 16'd1;
         if (end_fire && (type_reg == PKT_CRYPT))
            pkt_crypt_cnt_reg <= pkt_crypt_cnt_reg + 16'd1;
         if (err_fire && (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign pkt_init_cnt  = pkt_init_cnt_reg;
   assign pkt_crypt_cnt = pkt_crypt_cnt_reg;
   assign err_cnt       = err_cnt_reg;
`endif

endmodule

// File: tb/tb_bcrypt_dispatch_sched.sv
// Bench for bcrypt_dispatch_sched: directed scenarios plus randomized
// packets, compared against a packet-level model of proxy choice, hold-off
// timing, forwarded bytes and protocol-error count.
module tb_bcrypt_dispatch_sched;

   localparam int N  = 2;
   localparam int HO = 6;
   localparam int PW = 4;

   logic         CLK = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   s_din = '0;
   logic [1:0]   s_ctrl = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [7:0]   din;
   logic [1:0]   ctrl;
   logic [N-1:0] wr_en;
   logic [N-1:0] init_ready = '0;
   logic [N-1:0] crypt_ready = '0;
   logic         busy;
   logic         err_proto;
`ifdef BCRYPT_SCHED_STATS_EN
   logic [15:0]  pkt_init_cnt;
   logic [15:0]  pkt_crypt_cnt;
   logic [7:0]   err_cnt;
`endif

   always #5 CLK = ~CLK;

   bcrypt_dispatch_sched #(.NUM_PROXIES(N), .HOLDOFF(HO), .PTR_W(PW)) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .s_din       (s_din),
      .s_ctrl      (s_ctrl),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .din         (din),
      .ctrl        (ctrl),
      .wr_en       (wr_en),
      .init_ready  (init_ready),
      .crypt_ready (crypt_ready),
      .busy        (busy),
`ifdef BCRYPT_SCHED_STATS_EN
      .pkt_init_cnt  (pkt_init_cnt),
      .pkt_crypt_cnt (pkt_crypt_cnt),
      .err_cnt       (err_cnt),
`endif
      .err_proto   (err_proto)
   );

   typedef struct {
      int           cyc;
      logic [N-1:0] we;
      logic [1:0]   c;
      logic [7:0]   d;
   } rec_t;

   rec_t act_q[$];
   rec_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int err_seen = 0;

   // model state
   int last_end[N];
   int ptr_m = 0;
   int err_exp = 0;
   int n_init = 0;
   int n_crypt = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: one line per forwarded byte, records it for comparison
   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
         #1;
         if (wr_en !== '0) begin
            act_q.push_back('{cyc, wr_en, ctrl, din});
            $display("[%0d] out we=%b ctrl=%0d din=%h", cyc, wr_en, ctrl, din);
         end
         if (err_proto === 1'b1) err_seen++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic idle_cycle();
      @(negedge CLK);
      s_valid = 1'b0;
      @(posedge CLK);
   endtask

   // Present a byte until accepted; first_edge is the first clock edge that
   // sees it, acc_edge the edge that accepts it
   task automatic send_byte(input logic [7:0] d, input logic [1:0] c,
                            output int first_edge, output int acc_edge);
      int guard;
      bit done;
      guard = 0;
      done = 1'b0;
      first_edge = -1;
      acc_edge = -1;
      while (!done) begin
         @(negedge CLK);
         s_din = d;
         s_ctrl = c;
         s_valid = 1'b1;
         if (first_edge < 0) first_edge = cyc + 1;
         #1;
         if (s_ready === 1'b1) begin
            acc_edge = cyc + 1;
            done = 1'b1;
         end else begin
            guard++;
            if (guard > 400) begin
               check_val("accept_timeout", 64'd0, 64'd1);
               done = 1'b1;
            end
         end
         @(posedge CLK);
      end
   endtask

   // Proxy eligible at selection edge t if ready and its hold-off (loaded at
   // the edge its END was written, HO cycles long) has run out
   function automatic int model_pick(input logic [N-1:0] r, input int t);
      for (int k = 0; k < N; k++) begin
         int p;
         p = (ptr_m + k) % N;
         if (r[p] && (t > last_end[p] + HO)) return p;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) last_end[i] = -1000;
      ptr_m = 0;
      n_init = 0;
      n_crypt = 0;
   endtask

   task automatic compare_out(input string tag);
      rec_t a;
      rec_t e;
      #1;
      check_val({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && act_q.size() > 0) begin
         a = act_q.pop_front();
         e = exp_q.pop_front();
         check_val({tag, "_byte"}, {a.cyc, a.we, a.c, a.d}, {e.cyc, e.we, e.c, e.d});
      end
      act_q.delete();
      exp_q.delete();
      check_val({tag, "_err"}, 64'(err_seen), 64'(err_exp));
      check_val({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   // Finish the data/END part of a packet already routed to proxy p
   task automatic finish_packet(input int p, input bit is_init, input int nbytes,
                                input bit inject, input bit bubbles);
      logic [N-1:0] oh;
      logic [7:0] b;
      int fe, ae, inj_pos;
      oh = '0;
      oh[p] = 1'b1;
      inj_pos = inject ? int'($urandom_range(0, nbytes)) : -1;
      for (int i = 0; i <= nbytes; i++) begin
         if (i == inj_pos) begin
            send_byte(8'($urandom), 2'($urandom_range(1, 2)), fe, ae);
            err_exp++;
         end
         if (i < nbytes) begin
            if (bubbles && $urandom_range(0, 2) == 0) idle_cycle();
            b = 8'($urandom);
            send_byte(b, 2'd0, fe, ae);
            exp_q.push_back('{ae, oh, 2'd0, b});
         end
      end
      b = 8'($urandom);
      send_byte(b, 2'd3, fe, ae);
      exp_q.push_back('{ae, oh, 2'd3, b});
      last_end[p] = ae;
      ptr_m = (p + 1) % N;
      if (is_init) n_init++;
      else n_crypt++;
      repeat (2) idle_cycle();
   endtask

   task automatic run_packet(input string tag, input bit is_init, input int nbytes,
                             input bit stray, input bit inject, input bit bubbles, input int gap);
      logic [N-1:0] r;
      logic [N-1:0] oh;
      logic [1:0] sc;
      logic [7:0] b;
      int fe, ae, t, p;
      r = is_init ? init_ready : crypt_ready;
      if (stray) begin
         send_byte(8'($urandom), ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, fe, ae);
         err_exp++;
      end
      sc = is_init ? 2'd1 : 2'd2;
      b = 8'($urandom);
      send_byte(b, sc, fe, ae);
      t = fe + 1;
      while (model_pick(r, t) < 0 && t < fe + 64) t++;
      p = model_pick(r, t);
      check_val({tag, "_start_edge"}, 64'(ae), 64'(t + 1));
      if (p >= 0) begin
         oh = '0;
         oh[p] = 1'b1;
         exp_q.push_back('{t + 1, oh, sc, b});
         finish_packet(p, is_init, nbytes, inject, bubbles);
      end
      compare_out(tag);
      repeat (gap) idle_cycle();
   endtask

   int fe0, ae0, rc;

   initial begin
      model_reset();

      // reset values
      #2;
      check_val("rst_s_ready", 64'(s_ready), 64'd0);
      check_val("rst_wr_en", 64'(wr_en), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_err", 64'(err_proto), 64'd0);
      check_val("rst_din_ctrl", 64'({din, ctrl}), 64'd0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      rst_n = 1'b1;
      repeat (2) idle_cycle();

      // no proxy ready: start held, s_ready low, then init_ready[1] rises
      fork
         send_byte(8'h5A, 2'd1, fe0, ae0);
         begin
            repeat (20) begin
               @(negedge CLK);
               #2;
               check_val("hold_s_ready", 64'(s_ready), 64'd0);
               check_val("hold_wr_en", 64'(wr_en), 64'd0);
            end
            @(negedge CLK);
            init_ready = 2'b10;
            rc = cyc;
         end
      join
      check_val("late_dispatch", 64'((ae0 - rc) <= 3), 64'd1);
      exp_q.push_back('{ae0, 2'b10, 2'd1, 8'h5A});
      finish_packet(1, 1'b1, 1, 1'b0, 1'b0);
      compare_out("noready");

      // proxy 0 crypt-ready, proxy 1 init-ready
      crypt_ready = 2'b01;
      init_ready = 2'b10;
      run_packet("crypt_p0", 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);

      // both crypt-ready, back to back
      crypt_ready = 2'b11;
      run_packet("rr_a", 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);
      run_packet("rr_b", 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);

      // only proxy 0 ready: second packet waits out the hold-off
      crypt_ready = 2'b01;
      run_packet("hold_a", 1'b0, 1, 1'b0, 1'b0, 1'b0, 0);
      run_packet("hold_b", 1'b0, 1, 1'b0, 1'b0, 1'b0, 0);

      // stray byte in IDLE plus a start code inside the packet
      init_ready = 2'b11;
      run_packet("proto", 1'b1, 3, 1'b1, 1'b1, 1'b0, 1);

      // randomized packets
      for (int k = 0; k < 30; k++) begin
         bit is_init;
         is_init = 1'($urandom_range(0, 1));
         if (is_init) begin
            init_ready = 2'($urandom_range(1, 3));
            crypt_ready = 2'($urandom);
         end else begin
            crypt_ready = 2'($urandom_range(1, 3));
            init_ready = 2'($urandom);
         end
         run_packet("rand", is_init, int'($urandom_range(0, 5)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), int'($urandom_range(0, 8)));
      end

`ifdef BCRYPT_SCHED_STATS_EN
      check_val("stat_init", 64'(pkt_init_cnt), 64'(n_init));
      check_val("stat_crypt", 64'(pkt_crypt_cnt), 64'(n_crypt));
      check_val("stat_err", 64'(err_cnt), 64'((err_exp > 255) ? 255 : err_exp));
`endif

      // reset in the middle of a packet
      crypt_ready = 2'b11;
      send_byte(8'hA0, 2'd2, fe0, ae0);
      send_byte(8'hA1, 2'd0, fe0, ae0);
      @(negedge CLK);
      s_din = 8'hA2;
      s_ctrl = 2'd0;
      s_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_wr_en", 64'(wr_en), 64'd0);
      check_val("mid_rst_s_ready", 64'(s_ready), 64'd0);
      check_val("mid_rst_busy", 64'(busy), 64'd0);
      check_val("mid_rst_din", 64'({din, ctrl}), 64'd0);
`ifdef BCRYPT_SCHED_STATS_EN
      check_val("mid_rst_stats", 64'({pkt_init_cnt, pkt_crypt_cnt, err_cnt}), 64'd0);
`endif
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      s_valid = 1'b0;
      rst_n = 1'b1;
      act_q.delete();
      exp_q.delete();
      model_reset();
      repeat (2) idle_cycle();

      // scheduler works again from a clean pointer
      run_packet("post_rst", 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcrypt_dispatch_sched.md
Name: bcrypt_dispatch_sched

Overview:
- Ingress scheduler in front of the bcrypt proxy wrappers.
- Accepts a framed byte stream of init packets (salt/key setup) and crypt packets from the data-formatting stage.
- Picks one proxy per packet, round-robin among proxies whose matching ready flag is set, and streams the packet to it on the shared din/ctrl bus with a one-hot wr_en.
- Masks each proxy for a hold-off window after dispatch, because the proxy ready flags reach this block through 1–2 register stages and lag behind.

Parameters:
- NUM_PROXIES, 2, number of proxies driven (1..16).
- HOLDOFF, 6, cycles a proxy stays ineligible after its packet's END byte is written (1..15).
- PTR_W, 4, width of the round-robin pointer; must satisfy 2^PTR_W >= NUM_PROXIES.

Ports:
- CLK  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_din  in  8  source data byte.
- s_ctrl  in  2  source framing code: 0 DATA, 1 INIT_START, 2 CRYPT_START, 3 END.
- s_valid  in  1  source byte valid.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- din  out  8  byte to proxies.
- ctrl  out  2  framing code to proxies (same encoding).
- wr_en  out  NUM_PROXIES  one-hot write strobe.
- init_ready  in  NUM_PROXIES  proxy can take an init packet.
- crypt_ready  in  NUM_PROXIES  proxy can take a crypt packet.
- busy  out  1  high whenever state != IDLE.
- err_proto  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values: s_ready=0, din=0, ctrl=0, wr_en=0, busy=0, err_proto=0, rr_ptr=0, all hold-off counters=0, state=IDLE.
- Outputs are registered.
- States:
  - IDLE:
    - s_ready=1 only if s_ctrl is not a start code.
    - If s_valid with DATA or END: consume and drop the byte, pulse err_proto, stay in IDLE.
    - If s_valid with INIT_START or CRYPT_START: latch type, go to SELECT; the byte is not consumed.
  - SELECT:
    - s_ready=0.
    - elig = (type==INIT ? init_ready : crypt_ready) & ~holdoff_active.
    - If elig==0: wait.
    - Else choose the first set bit of elig at or after rr_ptr, wrapping modulo NUM_PROXIES; latch as sel; go to STREAM next cycle.
  - STREAM:
    - s_ready=1.
    - Each accepted byte appears next cycle: din=s_din, ctrl=s_ctrl, wr_en=onehot(sel). wr_en=0 on cycles with no acceptance.
    - The first byte forwarded is the start byte.
    - A further start code inside STREAM is dropped (not forwarded) with an err_proto pulse; the packet continues.
    - Accepted END: forwarded; holdoff[sel] loads HOLDOFF; rr_ptr <= (sel+1) mod NUM_PROXIES; go to IDLE.
- Latency:
  - Start byte presented in IDLE → start byte on din at the earliest 3 cycles later (IDLE → SELECT → STREAM accept → output).
  - Sustained throughput in STREAM: 1 byte/cycle.
- Hold-off: a counter is active while nonzero and decrements every cycle. A proxy just served can win again only after HOLDOFF cycles, and only if its ready flag is still set.
- Selection inputs are sampled in SELECT only. Ready flags dropping during STREAM do not abort the packet; proxies buffer a whole packet once ready.
- Simultaneous events: holdoff load on END takes priority over decrement for that index.
- NUM_PROXIES==1: pointer stays 0; hold-off still applies.
- Reset mid-packet: everything returns to reset values immediately; the truncated packet is discarded; proxies are reset by the same system reset.

Optional Feature:
- Macro: BCRYPT_SCHED_STATS_EN.
- Defined: adds outputs pkt_init_cnt[15:0] and pkt_crypt_cnt[15:0].
  - Each increments by 1 in the cycle an END is forwarded, selected by the latched type.
  - Wrap 0xFFFF→0; reset to 0.
  - Adds err_cnt[7:0], which saturates at 0xFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package bcrypt_sched_pkg: ctrl codes CTRL_DATA/CTRL_INIT_START/CTRL_CRYPT_START/CTRL_END, state enum {IDLE, SELECT, STREAM}, packet-type constants.
- Sub-module bcrypt_rr_pick: combinational rotate-priority encoder (elig, rr_ptr → sel, any). Instantiated once.

Test Plan:
- Proxy 0 crypt-ready and proxy 1 init-ready: send CRYPT_START,0x11,0x22,END → bytes appear on din with wr_en=2'b01 in 4 consecutive cycles, ctrl=2,0,0,3; busy drops after END.
- Both proxies crypt-ready: 2 back-to-back crypt packets → first to proxy 0, second to proxy 1; rr_ptr returns to 0.
- NUM_PROXIES=2, only proxy 0 ready, HOLDOFF=6: two packets back-to-back → second start byte reaches din no earlier than 6 cycles after the first END; wr_en=2'b01 both times.
- No proxy ready: start byte held in SELECT, s_ready=0 for 20 cycles; raise init_ready[1] → dispatch to proxy 1 within 3 cycles.
- DATA 0x55 in IDLE, then INIT_START inside a packet → two err_proto pulses, neither byte on din, packet completes normally.
- rst_n low mid-STREAM after 2 bytes → wr_en=0, s_ready=0, state IDLE immediately; with STATS_EN, counters read 0.
